// File: rtl/axi_w_burst_gate_pkg.sv
// Shared types and constants for the W-channel burst gate and its command queue.
package axi_w_burst_gate_pkg;

  localparam int unsigned DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORWARD = 2'd1,
    ST_DISCARD = 2'd2
  } gate_state_e;

  // Active state that a queued decision selects.
  function automatic gate_state_e cmd_state(input logic drop);
    return drop ? ST_DISCARD : ST_FORWARD;
  endfunction

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/axi_w_burst_gate_if.sv
// W-beat and command handshakes around the burst gate; slave is the gate's view.
interface axi_w_burst_gate_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] s_w_data;
  logic [STRB_W-1:0]     s_w_strb;
  logic                  s_w_last;
  logic                  s_w_valid;
  logic                  s_w_ready;

  logic                  cmd_drop;
  logic                  cmd_valid;
  logic                  cmd_ready;

  logic [DATA_WIDTH-1:0] m_w_data;
  logic [STRB_W-1:0]     m_w_strb;
  logic                  m_w_last;
  logic                  m_w_valid;
  logic                  m_w_ready;

  modport slave (
    input  s_w_data, s_w_strb, s_w_last, s_w_valid,
    input  cmd_drop, cmd_valid,
    input  m_w_ready,
    output s_w_ready, cmd_ready,
    output m_w_data, m_w_strb, m_w_last, m_w_valid
  );

  modport master (
    output s_w_data, s_w_strb, s_w_last, s_w_valid,
    output cmd_drop, cmd_valid,
    output m_w_ready,
    input  s_w_ready, cmd_ready,
    input  m_w_data, m_w_strb, m_w_last, m_w_valid
  );

endinterface

// File: rtl/axi_w_cmd_fifo.sv
// Register-based first-word fall-through queue of per-burst decisions.
// Also exposes the entry that becomes head if the current head pops this cycle.
module axi_w_cmd_fifo #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LOG_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             peek_valid,
  output logic [WIDTH-1:0] peek_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned CNT_W = LOG_DEPTH + 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0]     count;
  logic                 do_push;
  logic                 do_pop;
  logic                 has_second;

  function automatic logic [LOG_DEPTH-1:0] ptr_inc(input logic [LOG_DEPTH-1:0] p);
    return (p == LOG_DEPTH'(DEPTH - 1)) ? '0 : p + LOG_DEPTH'(1);
  endfunction

  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_nxt = ptr_inc(rd_ptr);
  assign has_second = (count > CNT_W'(1));

  assign head_data  = mem[rd_ptr];
  // With only one entry left, the successor can only be the word pushed now.
  assign peek_valid = has_second || do_push;
  assign peek_data  = has_second ? mem[rd_ptr_nxt] : push_data;

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_w_burst_gate.sv
// Per-burst W-channel gate: forwards or discards each burst as ordered by a
// queue of decisions, switching bursts without idle cycles.
module axi_w_burst_gate
  import axi_w_burst_gate_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CMD_DEPTH     = 4,
  parameter int unsigned LOG_CMD_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush_entries,
  axi_w_burst_gate_if.slave     bus,
  output logic                  drop_done,
  output logic [DROP_CNT_W-1:0] drop_beats
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  gate_state_e state_q;
  gate_state_e state_d;

  logic       push;
  logic       pop;
  logic       empty;
  logic       full;
  logic       peek_valid;
  logic [0:0] cmd_bit;
  logic [0:0] head_drop;
  logic [0:0] peek_drop;
  logic       s_ready;
  logic       m_valid;
  logic       beat_fire;
  logic       drop_beat;
  logic       drop_last;

  assign cmd_bit       = bus.cmd_drop;
  assign push          = bus.cmd_valid && !full;
  assign bus.cmd_ready = !full;

  axi_w_cmd_fifo #(
    .WIDTH     (1),
    .DEPTH     (CMD_DEPTH),
    .LOG_DEPTH (LOG_CMD_DEPTH)
  ) u_cmd_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush_entries),
    .push       (push),
    .push_data  (cmd_bit),
    .pop        (pop),
    .head_data  (head_drop),
    .peek_valid (peek_valid),
    .peek_data  (peek_drop),
    .empty      (empty),
    .full       (full)
  );

  // Payload passes straight through; only valid/ready are gated by state.
  assign bus.m_w_data  = DATA_WIDTH'(bus.s_w_data);
  assign bus.m_w_strb  = STRB_W'(bus.s_w_strb);
  assign bus.m_w_last  = bus.s_w_last;
  assign bus.m_w_valid = m_valid;
  assign bus.s_w_ready = s_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    pop       = 1'b0;
    drop_beat = 1'b0;
    drop_last = 1'b0;
    beat_fire = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d = cmd_state(head_drop[0]);
        end
      end
      ST_FORWARD: begin
        m_valid = bus.s_w_valid;
        s_ready = bus.m_w_ready;
      end
      ST_DISCARD: begin
        s_ready   = 1'b1;
        drop_beat = bus.s_w_valid;
        drop_last = bus.s_w_valid && bus.s_w_last;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    beat_fire = bus.s_w_valid && s_ready;

    // Burst end: retire the head and jump straight to the next decision, if any.
    if (beat_fire && bus.s_w_last) begin
      pop     = 1'b1;
      state_d = peek_valid ? cmd_state(peek_drop[0]) : ST_IDLE;
    end

    if (flush_entries) begin
      state_d = ST_IDLE;
    end
  end

  // Discard statistics; the beat counter survives flushes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_done  <= 1'b0;
      drop_beats <= '0;
    end else begin
      drop_done <= drop_last && !flush_entries;
      if (drop_beat) begin
        drop_beats <= sat_inc(drop_beats);
      end
    end
  end

endmodule
